// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing one SRAM-like bus between instruction fetch and MEM-stage data.
// One transaction in flight; flushed fetch responses are dropped rather than withdrawn.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,

  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,

  input  logic                  flush,

  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [1:0]            bus_size,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_W-1:0]     bus_rdata,

  output logic                  busy
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  state_e              state_q,      state_d;
  owner_e              owner_q,      owner_d;
  owner_e              last_owner_q, last_owner_d;
  logic                discard_q,    discard_d;
  logic                bus_req_q,    bus_req_d;
  logic                busy_q,       busy_d;

  logic [ADDR_W-1:0]   addr_q,       addr_d;
  logic                wr_q,         wr_d;
  logic [1:0]          size_q,       size_d;
  logic [STRB_W-1:0]   wstrb_q,      wstrb_d;
  logic [DATA_W-1:0]   wdata_q,      wdata_d;

  logic                inst_pend;
  logic                data_pend;
  logic                grant_inst;
  logic                addr_hit;
  logic                resp_hit;

  // A flushed fetch never competes; data requests are already gated by MEM.
  assign inst_pend = inst_req & ~flush;
  assign data_pend = data_req;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    discard_d    = discard_q;
    bus_req_d    = bus_req_q;
    busy_d       = busy_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    size_d       = size_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    grant_inst   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (inst_pend || data_pend) begin
          // On a tie the port that did not win last time goes first.
          grant_inst   = inst_pend && (!data_pend || (last_owner_q == OWN_DATA));
          state_d      = S_ADDR;
          bus_req_d    = 1'b1;
          busy_d       = 1'b1;
          discard_d    = 1'b0;
          if (grant_inst) begin
            owner_d      = OWN_INST;
            last_owner_d = OWN_INST;
            addr_d       = inst_addr;
            wr_d         = 1'b0;
            size_d       = 2'd2;
            wstrb_d      = '0;
            wdata_d      = '0;
          end else begin
            owner_d      = OWN_DATA;
            last_owner_d = OWN_DATA;
            addr_d       = data_addr;
            wr_d         = data_wr;
            size_d       = data_size;
            wstrb_d      = data_wr ? data_wstrb : '0;
            wdata_d      = data_wdata;
          end
        end
      end

      S_ADDR: begin
        if (flush && (owner_q == OWN_INST)) begin
          discard_d = 1'b1;
        end
        if (bus_addr_ok) begin
          state_d   = S_WAIT;
          bus_req_d = 1'b0;
        end
      end

      S_WAIT: begin
        if (bus_data_ok) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          discard_d = 1'b0;
        end else if (flush && (owner_q == OWN_INST)) begin
          discard_d = 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        bus_req_d = 1'b0;
        busy_d    = 1'b0;
        discard_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      last_owner_q <= OWN_INST;
      discard_q    <= 1'b0;
      bus_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      discard_q    <= discard_d;
      bus_req_q    <= bus_req_d;
      busy_q       <= busy_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
    end
  end

  // Slave handshakes only count in the state that is waiting for them.
  assign addr_hit = (state_q == S_ADDR) && bus_addr_ok;
  assign resp_hit = (state_q == S_WAIT) && bus_data_ok;

  assign inst_addr_ok = addr_hit && (owner_q == OWN_INST);
  assign data_addr_ok = addr_hit && (owner_q == OWN_DATA);
  assign inst_data_ok = resp_hit && (owner_q == OWN_INST) && !discard_q;
  assign data_data_ok = resp_hit && (owner_q == OWN_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  assign bus_req   = bus_req_q;
  assign bus_wr    = wr_q;
  assign bus_size  = size_q;
  assign bus_wstrb = wstrb_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct {
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [SW-1:0] data_wstrb;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          flush;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [DW-1:0] bus_rdata;
  } stim_t;

  typedef struct {
    bit            is_data;
    logic [AW-1:0] addr;
    logic          wr;
    logic [1:0]    size;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  stim_t cur;

  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic          bus_req, bus_wr, busy;
  logic [1:0]    bus_size;
  logic [SW-1:0] bus_wstrb;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  // Reference model: at most one transaction record, plus the fairness bit.
  bit   m_busy, m_acc, m_cancel, m_last_data;
  txn_t m_t;

  int cnt_bus_req, cnt_ddok, cnt_idok;
  bit grant_log[$];
  bit last_iaok, last_daok;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (cur.inst_req),
    .inst_addr    (cur.inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (cur.data_req),
    .data_wr      (cur.data_wr),
    .data_size    (cur.data_size),
    .data_wstrb   (cur.data_wstrb),
    .data_addr    (cur.data_addr),
    .data_wdata   (cur.data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .flush        (cur.flush),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_wstrb    (bus_wstrb),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (cur.bus_addr_ok),
    .bus_data_ok  (cur.bus_data_ok),
    .bus_rdata    (cur.bus_rdata),
    .busy         (busy)
  );

  function automatic stim_t idleStim();
    stim_t s;
    s.inst_req    = 1'b0;
    s.inst_addr   = '0;
    s.data_req    = 1'b0;
    s.data_wr     = 1'b0;
    s.data_size   = 2'd0;
    s.data_wstrb  = '0;
    s.data_addr   = '0;
    s.data_wdata  = '0;
    s.flush       = 1'b0;
    s.bus_addr_ok = 1'b0;
    s.bus_data_ok = 1'b0;
    s.bus_rdata   = '0;
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total = checks_total + 1;
    assert (obs === exp) checks_passed = checks_passed + 1;
    else begin
      checks_failed = checks_failed + 1;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_busy      = 1'b0;
    m_acc       = 1'b0;
    m_cancel    = 1'b0;
    m_last_data = 1'b0;
  endtask

  // Compare every output against the model for this cycle, then advance the model.
  task automatic stepModel();
    bit e_req, e_iaok, e_daok, e_idok, e_ddok, want_i, want_d, pick_d;
    e_req  = m_busy && !m_acc;
    e_iaok = e_req && !m_t.is_data && cur.bus_addr_ok;
    e_daok = e_req && m_t.is_data && cur.bus_addr_ok;
    e_idok = m_busy && m_acc && !m_t.is_data && cur.bus_data_ok && !m_cancel;
    e_ddok = m_busy && m_acc && m_t.is_data && cur.bus_data_ok;

    checkOutput("busy", busy, m_busy);
    checkOutput("bus_req", bus_req, e_req);
    checkOutput("inst_addr_ok", inst_addr_ok, e_iaok);
    checkOutput("data_addr_ok", data_addr_ok, e_daok);
    checkOutput("inst_data_ok", inst_data_ok, e_idok);
    checkOutput("data_data_ok", data_data_ok, e_ddok);
    if (e_req) begin
      checkOutput("bus_addr", bus_addr, m_t.addr);
      checkOutput("bus_wr", bus_wr, m_t.wr);
      checkOutput("bus_size", bus_size, m_t.size);
      checkOutput("bus_wstrb", bus_wstrb, m_t.wstrb);
      if (m_t.is_data) checkOutput("bus_wdata", bus_wdata, m_t.wdata);
    end
    if (e_idok) checkOutput("inst_rdata", inst_rdata, cur.bus_rdata);
    if (e_ddok) checkOutput("data_rdata", data_rdata, cur.bus_rdata);

    if (bus_req) cnt_bus_req++;
    if (data_data_ok) cnt_ddok++;
    if (inst_data_ok) cnt_idok++;
    if (data_addr_ok) grant_log.push_back(1'b1);
    if (inst_addr_ok) grant_log.push_back(1'b0);
    last_iaok = inst_addr_ok;
    last_daok = data_addr_ok;

    if (!m_busy) begin
      want_i = cur.inst_req && !cur.flush;
      want_d = cur.data_req;
      if (want_i || want_d) begin
        pick_d    = want_d && !(want_i && m_last_data);
        m_t.is_data = pick_d;
        if (pick_d) begin
          m_t.addr  = cur.data_addr;
          m_t.wr    = cur.data_wr;
          m_t.size  = cur.data_size;
          m_t.wstrb = cur.data_wr ? cur.data_wstrb : '0;
          m_t.wdata = cur.data_wdata;
        end else begin
          m_t.addr  = cur.inst_addr;
          m_t.wr    = 1'b0;
          m_t.size  = 2'd2;
          m_t.wstrb = '0;
          m_t.wdata = '0;
        end
        m_busy      = 1'b1;
        m_acc       = 1'b0;
        m_cancel    = 1'b0;
        m_last_data = pick_d;
      end
    end else begin
      if (!m_t.is_data && cur.flush) m_cancel = 1'b1;
      if (!m_acc) begin
        if (cur.bus_addr_ok) m_acc = 1'b1;
      end else if (cur.bus_data_ok) begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    cur = s;
    @(negedge clk);
    stepModel();
  endtask

  task automatic doReset();
    cur = idleStim();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_bus_req", bus_req, 0);
    checkOutput("rst_bus_fields", {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, 0);
    checkOutput("rst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  task automatic drainIdle();
    stim_t s;
    s = idleStim();
    s.bus_addr_ok = 1'b1;
    s.bus_data_ok = 1'b1;
    for (int i = 0; i < 6 && m_busy; i++) applyStimulus(s);
    s = idleStim();
    applyStimulus(s);
    checkOutput("drain_idle", busy, 0);
  endtask

  initial begin
    stim_t s;
    rst = 1'b0;
    cur = idleStim();
    modelReset();
    cnt_bus_req = 0; cnt_ddok = 0; cnt_idok = 0;
    doReset();

    // Single fetch with an immediately accepting slave.
    s = idleStim();
    s.inst_req = 1'b1; s.inst_addr = 32'hBFC0_0000; s.bus_addr_ok = 1'b1;
    applyStimulus(s);
    checkOutput("t1_c0_bus_req", bus_req, 0);
    applyStimulus(s);
    checkOutput("t1_c1_bus_req", bus_req, 1);
    checkOutput("t1_c1_size", bus_size, 2);
    checkOutput("t1_c1_wstrb", bus_wstrb, 0);
    checkOutput("t1_c1_addr", bus_addr, 32'hBFC0_0000);
    checkOutput("t1_c1_addr_ok", inst_addr_ok, 1);
    s = idleStim();
    s.bus_data_ok = 1'b1; s.bus_rdata = 32'h3C08_0001;
    applyStimulus(s);
    checkOutput("t1_c2_data_ok", inst_data_ok, 1);
    checkOutput("t1_c2_rdata", inst_rdata, 32'h3C08_0001);
    s = idleStim();
    applyStimulus(s);
    checkOutput("t1_c3_busy", busy, 0);

    // Byte store with the slave holding off address acceptance for 3 cycles.
    cnt_bus_req = 0; cnt_ddok = 0;
    s = idleStim();
    s.data_req = 1'b1; s.data_wr = 1'b1; s.data_size = 2'd0; s.data_wstrb = 4'b0100;
    s.data_addr = 32'h8000_0002; s.data_wdata = 32'h00AB_0000;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) applyStimulus(s);
    s.bus_addr_ok = 1'b1;
    applyStimulus(s);
    checkOutput("t2_addr_ok", data_addr_ok, 1);
    s = idleStim();
    s.bus_data_ok = 1'b1;
    applyStimulus(s);
    s = idleStim();
    applyStimulus(s);
    applyStimulus(s);
    checkOutput("t2_bus_req_cycles", cnt_bus_req, 4);
    checkOutput("t2_data_ok_pulses", cnt_ddok, 1);

    // Both ports held continuously after reset: strict alternation starting with DATA.
    doReset();
    grant_log.delete();
    s = idleStim();
    s.inst_req = 1'b1; s.inst_addr = 32'h0000_1000;
    s.data_req = 1'b1; s.data_addr = 32'h0000_2000;
    s.bus_addr_ok = 1'b1; s.bus_data_ok = 1'b1; s.bus_rdata = 32'h0BAD_F00D;
    for (int i = 0; i < 13; i++) applyStimulus(s);
    checkOutput("t3_grant_count", grant_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() > i) checkOutput($sformatf("t3_grant%0d", i), grant_log[i], (i % 2 == 0) ? 1 : 0);
    end
    drainIdle();

    // Fetch flushed while waiting for data: response dropped, next fetch clean.
    cnt_idok = 0;
    s = idleStim();
    s.inst_req = 1'b1; s.inst_addr = 32'h0000_0040; s.bus_addr_ok = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    s = idleStim();
    s.flush = 1'b1;
    applyStimulus(s);
    s = idleStim();
    s.bus_data_ok = 1'b1; s.bus_rdata = 32'hDEAD_BEEF;
    applyStimulus(s);
    checkOutput("t4_dropped", inst_data_ok, 0);
    checkOutput("t4_busy_at_resp", busy, 1);
    s = idleStim();
    applyStimulus(s);
    checkOutput("t4_busy_after", busy, 0);
    s.inst_req = 1'b1; s.inst_addr = 32'h0000_0044; s.bus_addr_ok = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    s = idleStim();
    s.bus_data_ok = 1'b1; s.bus_rdata = 32'h2402_0005;
    applyStimulus(s);
    checkOutput("t4_next_fetch", inst_data_ok, 1);
    checkOutput("t4_fetch_pulses", cnt_idok, 1);

    // Load with flush asserted throughout still completes.
    s = idleStim();
    s.data_req = 1'b1; s.data_addr = 32'h8000_0100; s.data_size = 2'd2;
    s.flush = 1'b1; s.bus_addr_ok = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    s = idleStim();
    s.flush = 1'b1; s.bus_data_ok = 1'b1; s.bus_rdata = 32'h1234_5678;
    applyStimulus(s);
    checkOutput("t5_data_ok", data_data_ok, 1);
    checkOutput("t5_rdata", data_rdata, 32'h1234_5678);

    // Asynchronous reset while a DATA transaction sits in ADDR.
    s = idleStim();
    s.data_req = 1'b1; s.data_addr = 32'h8000_0200;
    applyStimulus(s);
    applyStimulus(s);
    checkOutput("t6_pre_bus_req", bus_req, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t6_async_bus_req", bus_req, 0);
    checkOutput("t6_async_busy", busy, 0);
    cur = idleStim();
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    modelReset();
    s = idleStim();
    s.inst_req = 1'b1; s.inst_addr = 32'h0000_0080;
    s.data_req = 1'b1; s.data_addr = 32'h8000_0300;
    s.bus_addr_ok = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    checkOutput("t6_data_first", data_addr_ok, 1);
    checkOutput("t6_inst_not_first", inst_addr_ok, 0);
    drainIdle();

    // Random traffic: requesters hold until accepted, slave handshakes arrive at random.
    s = idleStim();
    last_iaok = 1'b0;
    last_daok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (s.inst_req && last_iaok) s.inst_req = 1'b0;
      if (!s.inst_req && ($urandom_range(0, 2) == 0)) begin
        s.inst_req  = 1'b1;
        s.inst_addr = {$urandom()} & 32'hFFFF_FFFC;
      end
      if (s.data_req && last_daok) s.data_req = 1'b0;
      if (!s.data_req && ($urandom_range(0, 2) == 0)) begin
        s.data_req   = 1'b1;
        s.data_wr    = 1'($urandom_range(0, 1));
        s.data_size  = 2'($urandom_range(0, 2));
        s.data_wstrb = 4'($urandom());
        s.data_addr  = $urandom();
        s.data_wdata = $urandom();
      end
      s.flush       = ($urandom_range(0, 5) == 0);
      s.bus_addr_ok = 1'($urandom_range(0, 1));
      s.bus_data_ok = 1'($urandom_range(0, 1));
      s.bus_rdata   = $urandom();
      applyStimulus(s);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch port and the MEM-stage data port (the memsel/cp0 stage).
- One outstanding transaction at a time; request/addr_ok/data_ok handshakes on both sides.
- Requester side always sees a clean per-port handshake.
- Discards instruction responses cancelled by a pipeline flush (exception/eret from MEM).

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; byte strobe width is DATA_W/8

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous and active-low
inst_req  in  1  fetch request; held until inst_addr_ok
inst_addr  in  ADDR_W  fetch address
inst_addr_ok  out  1  fetch request accepted
inst_data_ok  out  1  fetch data valid, one-cycle pulse
inst_rdata  out  DATA_W  fetch data
data_req  in  1  data request; held until data_addr_ok
data_wr  in  1  1 = store, 0 = load
data_size  in  2  0 = byte, 1 = half, 2 = word
data_wstrb  in  DATA_W/8  byte enables for stores
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  store data
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  load data valid / store done, one-cycle pulse
data_rdata  out  DATA_W  load data
flush  in  1  pipeline flush; cancels in-flight fetch
bus_req  out  1  bus request
bus_wr  out  1  bus write
bus_size  out  2  bus size
bus_wstrb  out  DATA_W/8  bus byte enables
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_addr_ok  in  1  slave accepted request
bus_data_ok  in  1  slave response valid
bus_rdata  in  DATA_W  slave read data
busy  out  1  transaction in progress

Behaviour:
Reset (rst = 0, asynchronous):
- state = IDLE, owner = INST, last_owner = INST, discard = 0.
- All bus_* outputs and all *_ok outputs are 0. busy = 0.
- Reset mid-transaction abandons it silently; no ok pulse is produced.

IDLE:
- Grant when any request is pending: data_req, or inst_req with flush = 0.
- Tie (both pending): grant INST if last_owner = DATA, else DATA. Guarantees alternation; no starvation.
- On grant, latch the winner's addr/wr/size/wstrb/wdata into request registers; set owner and last_owner; go to ADDR on the next edge.
- Fetch latches wr = 0, size = 2, wstrb = 0. Data loads force wstrb = 0.

ADDR:
- bus_req = 1; bus_* driven only from the latched registers.
- Owner's addr_ok = bus_addr_ok, combinational, same cycle. On bus_addr_ok go to WAIT.

WAIT:
- bus_req = 0.
- On bus_data_ok: owner's data_ok = 1 for that cycle; owner's rdata = bus_rdata; go to IDLE.
- Exception: when owner = INST and discard = 1, inst_data_ok stays 0.

Flush:
- flush in IDLE suppresses inst_req for that cycle.
- flush in ADDR or WAIT while owner = INST sets discard.
- The bus request is never withdrawn once bus_req is asserted; the transaction completes and its response is dropped.
- discard clears on return to IDLE.
- flush has no effect on data transactions; MEM gates data_req itself.

Output rules and timing:
- busy = (state != IDLE).
- Non-owner ok outputs are always 0. rdata outputs are don't-care when their data_ok is 0.
- Latency: request seen in cycle 0 -> bus_req in cycle 1 -> earliest data_ok in cycle 2.
- Minimum of 3 cycles per transaction.
- bus_addr_ok or bus_data_ok arriving outside the matching state is ignored.

Test Plan:
1. Single fetch: inst_req, inst_addr = 0xBFC00000; slave accepts immediately, returns 0x3C080001 one cycle later -> bus_req in cycle 1 with bus_size = 2, bus_wstrb = 0; inst_addr_ok in cycle 1; inst_data_ok + inst_rdata = 0x3C080001 in cycle 2.
2. Byte store: data_req, wr = 1, size = 0, wstrb = 4'b0100, addr = 0x80000002, wdata = 0x00AB0000; slave addr_ok delayed 3 cycles -> bus_req held 4 cycles with stable fields; data_data_ok pulses once.
3. Simultaneous inst_req and data_req, held continuously after reset -> grant order DATA, INST, DATA, INST; no ok pulse ever on the non-owner port.
4. Fetch in WAIT, flush pulsed one cycle, response 0xDEADBEEF -> inst_data_ok stays 0; busy falls after bus_data_ok; the next fetch completes normally.
5. Load in progress with flush asserted -> data_data_ok still pulses with bus_rdata = 0x12345678.
6. rst driven low during ADDR, asynchronously mid-cycle -> bus_req and busy drop immediately; after release the arbiter is IDLE and the DATA-first tie rule is restored.
